// File: rtl/pdf_key_checker_pkg.sv
// Shared definitions for the PDF key search checker: controller states,
// default search parameters and the candidate tag layout.
package pdf_key_checker_pkg;

    localparam int unsigned LATENCY_DEF = 32;
    localparam logic [63:0] MAGIC_DEF   = 64'h255044462D312E00;
    localparam logic [63:0] MASK_DEF    = 64'hFFFFFFFFFFFFFF00;
    localparam int          TAG_W       = 32;

    // Candidate tag: generator mode in bit 31, bit 30 always zero, LFSR value below.
    typedef struct packed {
        logic        mode;
        logic        zero;
        logic [29:0] lfsr;
    } tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEARCH,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } state_e;

    function automatic tag_t make_tag(input logic mode, input logic [29:0] lfsr);
        make_tag = {mode, 1'b0, lfsr};
    endfunction

endpackage

// File: rtl/pdf_key_checker_tag_delay_line.sv
// Shift register that carries each candidate tag alongside its block through
// the decryption pipeline, so the output tap lines up with the decrypted data.
module tag_delay_line #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pdf_key_checker.sv
// Key search controller: compares decrypted blocks against the PDF header magic
// and reports the candidate tag that produced it, or that the search ran out.
//
//   state      | meaning
//   IDLE       | waiting for start, last result still readable
//   FILL       | pipeline filling, no compares
//   SEARCH     | comparing, counting generator period ends
//   DRAIN      | both modes issued, comparing in-flight candidates
//   FOUND      | match reported, waiting for ack
//   EXHAUSTED  | no match, waiting for ack
module pdf_key_checker
    import pdf_key_checker_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter logic [63:0] MAGIC   = MAGIC_DEF,
    parameter logic [63:0] MASK    = MASK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic [TAG_W-1:0] cand_in,
    input  logic             period_end,
    input  logic [63:0]      decrypted,
    output logic [TAG_W-1:0] found_key,
    output logic             rdy,
    output logic             miss,
    output logic             busy,
    output logic [31:0]      tested
);

    localparam logic [31:0] CNT_LOAD = 32'(LATENCY - 1);

    state_e           state_q;
    logic [31:0]      cnt_q;
    logic [1:0]       pe_cnt_q;
    logic [TAG_W-1:0] found_key_q;
    logic [31:0]      tested_q;
    logic [31:0]      tested_d;
    logic             rdy_q;
    logic             miss_q;
    logic             busy_q;
    logic [TAG_W-1:0] tag_tap;
    logic             match;

    tag_delay_line #(
        .DEPTH (int'(LATENCY)),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk   (clk),
        .rst   (rst),
        .tag_i (cand_in),
        .tag_o (tag_tap)
    );

    assign match    = (decrypted & MASK) == (MAGIC & MASK);
    assign tested_d = (tested_q == 32'hFFFF_FFFF) ? tested_q : tested_q + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pe_cnt_q    <= '0;
            found_key_q <= '0;
            tested_q    <= '0;
            rdy_q       <= 1'b0;
            miss_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_FILL;
                        cnt_q       <= CNT_LOAD;
                        pe_cnt_q    <= '0;
                        tested_q    <= '0;
                        found_key_q <= '0;
                        miss_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                    // Exit so the first compare meets the start-cycle candidate at the tap.
                    if (cnt_q <= 32'd1) begin
                        state_q <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    tested_q <= tested_d;
                    if (match) begin
                        found_key_q <= tag_tap;
                        state_q     <= ST_FOUND;
                        rdy_q       <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (period_end) begin
                        if (pe_cnt_q == 2'd1) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= CNT_LOAD;
                        end
                        pe_cnt_q <= pe_cnt_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    tested_q <= tested_d;
                    if (match) begin
                        found_key_q <= tag_tap;
                        state_q     <= ST_FOUND;
                        rdy_q       <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_EXHAUSTED;
                        rdy_q   <= 1'b1;
                        miss_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                ST_FOUND, ST_EXHAUSTED: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign found_key = found_key_q;
    assign rdy       = rdy_q;
    assign miss      = miss_q;
    assign busy      = busy_q;
    assign tested    = tested_q;

endmodule

// File: doc/pdf_key_checker.md
PDF_KEY_CHECKER -- requirements
Module: pdf_key_checker

Interface
REQ-001 Parameter LATENCY, default 32, clock cycles from candidate issue to decrypted block at the TEA pipeline output.
REQ-002 Parameter MAGIC, default 64'h255044462D312E00, expected plaintext ("%PDF-1.").
REQ-003 Parameter MASK, default 64'hFFFFFFFFFFFFFF00, bits of MAGIC compared (last byte is the don't-care version digit).
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a search; honoured only in IDLE.
REQ-007 ack  in  1  host acknowledge of a result; honoured only in FOUND or EXHAUSTED.
REQ-008 cand_in  in  32  candidate tag {mode, 1'b0, lfsr[29:0]} issued this cycle by the key generator.
REQ-009 period_end  in  1  generator pulse marking the end of one LFSR period.
REQ-010 decrypted  in  64  TEA pipeline output, {dataA', dataB'}.
REQ-011 found_key  out  32  candidate tag whose decryption matched.
REQ-012 rdy  out  1  result available (FOUND or EXHAUSTED).
REQ-013 miss  out  1  search finished without a match.
REQ-014 busy  out  1  high in FILL, SEARCH, DRAIN.
REQ-015 tested  out  32  number of candidates compared since start.

Function
REQ-016 A LATENCY-deep, 32-bit delay line SHALL shift cand_in every clock, so tap LATENCY-1 carries the tag belonging to the current decrypted.
REQ-017 States SHALL be IDLE, FILL, SEARCH, DRAIN, FOUND, EXHAUSTED.
REQ-018 IDLE + start -> FILL; a down-counter SHALL load LATENCY-1, and tested, found_key, and miss SHALL clear.
REQ-019 FILL SHALL decrement each clock and move to SEARCH on the cycle after the count reaches 0; no compares SHALL occur in FILL.
REQ-020 In SEARCH and DRAIN, a match is (decrypted & MASK) == (MAGIC & MASK); each compared cycle SHALL increment tested, saturating at 32'hFFFFFFFF.
REQ-021 On a match, the delayed tag SHALL latch into found_key on that edge, state -> FOUND, rdy=1 from the next cycle.
REQ-022 A period_end counter SHALL count pulses in SEARCH; the second pulse (both modes covered) -> DRAIN with the down-counter loaded to LATENCY-1.
REQ-023 DRAIN SHALL keep comparing so in-flight candidates are still tested; at count 0 with no match -> EXHAUSTED, miss=1, rdy=1.
REQ-024 If a match and the second period_end coincide, or a match and the DRAIN terminal count coincide, the match SHALL win (FOUND).
REQ-025 FOUND and EXHAUSTED SHALL hold all outputs until ack, then -> IDLE with rdy=0; found_key and tested SHALL stay readable in IDLE.
REQ-026 start outside IDLE and ack outside FOUND/EXHAUSTED SHALL be ignored; if start and ack arrive in the same cycle, ack is taken and start is dropped.
REQ-027 Output latency: rdy SHALL rise exactly 1 clock after the matching decrypted is presented.

Reset
REQ-028 rst low SHALL asynchronously force IDLE and set found_key=0, rdy=0, miss=0, busy=0, tested=0, counters=0, and delay line=0.
REQ-029 Reset mid-search SHALL abandon the search with no result, and a new start SHALL be required.

Structure
REQ-030 The shared package SHALL hold the state encoding, LATENCY default, MAGIC, MASK, and the tag layout (mode bit 31, bit 30 zero, lfsr 29:0).
REQ-031 The delay line SHALL be one sub-module, tag_delay_line (parameters DEPTH, WIDTH); the FSM, counters, and comparator stay in the top.

Verification
REQ-032 Start; cand_in=k ramping; decrypted=MAGIC exactly LATENCY+5 clocks after start -> FOUND, found_key = tag issued at cycle 5, rdy 1 clock later, tested=6.
REQ-033 decrypted=64'h255044462D312E37 (digit '7') -> match accepted; 64'h255044462D312F00 -> no match.
REQ-034 No match; two period_end pulses; then LATENCY clocks -> EXHAUSTED, miss=1, rdy=1; ack -> IDLE, rdy=0 next clock.
REQ-035 Match on the same clock as the second period_end -> FOUND, miss=0.
REQ-036 rst low for 1 cycle during SEARCH -> all outputs 0 immediately; a MAGIC presented afterwards without a new start -> no response.
REQ-037 start pulsed in SEARCH and FOUND -> no state change; ack in SEARCH -> ignored.
